count_checker: RTL and testbench
================================

COUNT_CHECKER -- requirements
Module: count_checker

Interface
REQ-001 Parameter WIDTH, default 8: bit width of the observed count.
REQ-002 Parameter LOCK_N, default 2: consecutive correct steps required to lock (legal 1..15).
REQ-003 Port clk  input  1: sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1: synchronous reset, active-high.
REQ-005 Port sample_valid  input  1: sample is presented this cycle.
REQ-006 Port sample  input  WIDTH: observed counter value, e.g. a counter block's uo_out.
REQ-007 Port dir  input  1: expected direction, 0=up, 1=down; effect governed by REQ-027.
REQ-008 Port locked  output  1: checker is locked to the sequence.
REQ-009 Port err_pulse  output  1: one-cycle flag for a mismatch while locked.
REQ-010 Port err_count  output  8: saturating count of mismatches.
REQ-011 Port state  output  2: current FSM state encoding.
REQ-012 Port expected  output  WIDTH: next value the checker expects.

Function
REQ-013 FSM states: IDLE=0, SYNC=1, LOCKED=2; encoding 3 unused and SHALL recover to IDLE on the next edge.
REQ-014 All outputs registered; response to a valid sample visible on the cycle after the sampling edge.
REQ-015 Cycles with sample_valid=0 SHALL change no state, counter or output, except that err_pulse returns to 0.
REQ-016 IDLE + valid: seed expected = sample +/- 1 (per direction), clear match counter, go to SYNC.
REQ-017 SYNC + valid + sample==expected: increment match counter, advance expected; on reaching LOCK_N go to LOCKED and assert locked.
REQ-018 SYNC + valid + mismatch: reseed expected from sample, clear match counter, stay in SYNC, no err_pulse, err_count unchanged.
REQ-019 LOCKED + valid + match: advance expected, stay LOCKED.
REQ-020 LOCKED + valid + mismatch: err_pulse=1 for one cycle, err_count+1 (saturate at 255), deassert locked, reseed from sample, go to SYNC.
REQ-021 Arithmetic modulo 2^WIDTH: up wraps max->0, down wraps 0->max; wrap steps are correct steps, not errors.
REQ-022 Two back-to-back valid mismatches in LOCKED: first yields err_pulse; second is a SYNC reseed and yields none.
REQ-023 err_count at 255 SHALL hold 255 on further errors; err_pulse still asserts.

Reset
REQ-024 rst=1 at a clock edge: state=IDLE, locked=0, err_pulse=0, err_count=0, expected=0, match counter=0.
REQ-025 rst takes priority over a simultaneous sample_valid; that sample is discarded.
REQ-026 Reset asserted mid-sequence (SYNC or LOCKED) SHALL fully restore REQ-024 values; no partial state retained.

Configuration
REQ-027 Macro COUNT_CHECKER_DIR_EN defined: dir is sampled with each valid sample and selects +1 (dir=0) or -1 (dir=1) for seeding and advancing.
REQ-028 Macro COUNT_CHECKER_DIR_EN undefined: dir ignored, direction fixed up (+1); port remains present.

Verification
REQ-029 Reset, then valid samples 5,6,7 -> locked=1 one cycle after sample 7, state=2, expected=8, err_count=0.
REQ-030 Locked at expected=254, samples 254,255,0,1 -> locked stays 1, err_pulse never asserts, expected=2.
REQ-031 Locked at expected=10, sample 40 -> err_pulse=1 for exactly one cycle, err_count=1, state=1, expected=41; then 41,42 -> relock.
REQ-032 Force 256 lock/mismatch cycles -> err_count saturates at 255 and holds; err_pulse still fires on each further error.
REQ-033 Locked, rst=1 coincident with valid sample -> next cycle state=0, all outputs zero, sample ignored.
REQ-034 With COUNT_CHECKER_DIR_EN, dir=1, samples 1,0,255 -> locked=1, expected=254; without macro same stimulus -> no lock, state=1.

Source files
------------

// File: rtl/count_checker.sv
// count_checker: locks onto an externally observed counter sequence and flags
// steps that break the sequence once locked.
// Optional feature macro: COUNT_CHECKER_DIR_EN -- when defined, dir selects up (0)
// or down (1) stepping per valid sample; when undefined, stepping is fixed up and
// dir is ignored.
module count_checker #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned LOCK_N = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] sample,
  input  logic             dir,
  output logic             locked,
  output logic             err_pulse,
  output logic [7:0]       err_count,
  output logic [1:0]       state,
  output logic [WIDTH-1:0] expected
);

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSync   = 2'd1,
    StLocked = 2'd2,
    StBad    = 2'd3
  } state_e;

  localparam logic [3:0] LockN = 4'(LOCK_N);

  state_e           r_state;
  state_e           w_state_d;
  logic [3:0]       r_match;
  logic [3:0]       w_match_d;
  logic [WIDTH-1:0] r_expected;
  logic [WIDTH-1:0] w_expected_d;
  logic [7:0]       r_err_count;
  logic [7:0]       w_err_count_d;
  logic             r_err_pulse;
  logic             w_err_pulse_d;
  logic             r_locked;
  logic             w_locked_d;

  logic             w_down;
  logic [WIDTH-1:0] w_seed;
  logic             w_hit;
  logic [3:0]       w_match_inc;

`ifdef COUNT_CHECKER_DIR_EN
  assign w_down = dir;
`else
  // Port kept for pin compatibility; direction is fixed up.
  logic w_unused_dir;
  assign w_unused_dir = dir;
  assign w_down       = 1'b0;
`endif

  // On a match, sample equals r_expected, so seeding and advancing are the same step.
  assign w_seed      = w_down ? (sample - WIDTH'(1)) : (sample + WIDTH'(1));
  assign w_hit       = (sample == r_expected);
  assign w_match_inc = r_match + 4'd1;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_d;
    end
  end

  // Next-state logic; unused encoding falls back to idle unconditionally
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      StIdle: begin
        if (sample_valid) w_state_d = StSync;
      end
      StSync: begin
        if (sample_valid && w_hit && (w_match_inc == LockN)) w_state_d = StLocked;
      end
      StLocked: begin
        if (sample_valid && !w_hit) w_state_d = StSync;
      end
      default: w_state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs and match counter
  always_comb begin
    w_expected_d  = r_expected;
    w_match_d     = r_match;
    w_err_count_d = r_err_count;
    w_err_pulse_d = 1'b0;
    if (sample_valid) begin
      case (r_state)
        StIdle: begin
          w_expected_d = w_seed;
          w_match_d    = 4'd0;
        end
        StSync: begin
          w_expected_d = w_seed;
          w_match_d    = w_hit ? w_match_inc : 4'd0;
        end
        StLocked: begin
          w_expected_d = w_seed;
          if (!w_hit) begin
            w_match_d     = 4'd0;
            w_err_pulse_d = 1'b1;
            if (r_err_count != 8'hFF) w_err_count_d = r_err_count + 8'd1;
          end
        end
        default: ;
      endcase
    end
    w_locked_d = (w_state_d == StLocked);
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_expected  <= '0;
      r_match     <= 4'd0;
      r_err_count <= 8'd0;
      r_err_pulse <= 1'b0;
      r_locked    <= 1'b0;
    end else begin
      r_expected  <= w_expected_d;
      r_match     <= w_match_d;
      r_err_count <= w_err_count_d;
      r_err_pulse <= w_err_pulse_d;
      r_locked    <= w_locked_d;
    end
  end

  assign state     = r_state;
  assign locked    = r_locked;
  assign err_pulse = r_err_pulse;
  assign err_count = r_err_count;
  assign expected  = r_expected;

endmodule

// File: tb/tb_count_checker.sv
// Self-checking bench for count_checker with a streak-based reference model.
module tb_count_checker;

  localparam int LN = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sample_valid = 1'b0;
  logic [7:0] sample = 8'd0;
  logic       dir = 1'b0;
  logic       locked;
  logic       err_pulse;
  logic [7:0] err_count;
  logic [1:0] state;
  logic [7:0] expected;

  count_checker #(
    .WIDTH  (8),
    .LOCK_N (LN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .sample       (sample),
    .dir          (dir),
    .locked       (locked),
    .err_pulse    (err_pulse),
    .err_count    (err_count),
    .state        (state),
    .expected     (expected)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Model: a run of consecutive correct steps since the last break; locked iff run >= LN.
  bit m_have;
  int m_exp;
  int m_streak;
  int m_err;
  bit m_pulse;

  logic [19:0] dut_vec;
  assign dut_vec = {state, locked, err_pulse, err_count, expected};

  function automatic int stepv(input bit d);
`ifdef COUNT_CHECKER_DIR_EN
    return d ? -1 : 1;
`else
    return 1;
`endif
  endfunction

  function automatic logic [19:0] m_vec();
    int st;
    bit lk;
    lk = m_have && (m_streak >= LN);
    st = !m_have ? 0 : (lk ? 2 : 1);
    return {2'(st), lk, m_pulse, 8'(m_err), 8'(m_exp)};
  endfunction

  task automatic cyc(input bit r, input bit v, input int s, input bit d);
    int sv;
    sv = s & 255;
    rst = r; sample_valid = v; sample = 8'(sv); dir = d;
    @(posedge clk);
    if (r) begin
      m_have = 0; m_exp = 0; m_streak = 0; m_err = 0; m_pulse = 0;
    end else begin
      m_pulse = 0;
      if (v) begin
        if (!m_have) begin
          m_have = 1; m_streak = 0;
        end else if (sv == m_exp) begin
          if (m_streak < LN) m_streak++;
        end else begin
          if (m_streak >= LN) begin
            m_pulse = 1;
            if (m_err < 255) m_err++;
          end
          m_streak = 0;
        end
        m_exp = (sv + 256 + stepv(d)) % 256;
      end
    end
    #1;
    rst = 1'b0; sample_valid = 1'b0;
  endtask

  task automatic test_reset();
    cyc(1, 0, 0, 0);
    cyc(1, 1, 33, 0);
    n_checks++;
    if (dut_vec !== 20'h0) begin
      n_errors++;
      $display("FAIL reset_zero: got %h required %h", dut_vec, 20'h0);
    end
    cyc(0, 0, 0, 0);
    n_checks++;
    if (dut_vec !== m_vec()) begin
      n_errors++;
      $display("FAIL reset_idle: got %h required %h", dut_vec, m_vec());
    end
  endtask

  task automatic test_lock();
    int seq[3] = '{5, 6, 7};
    cyc(1, 0, 0, 0);
    foreach (seq[i]) begin
      cyc(0, 1, seq[i], 0);
      n_checks++;
      if (dut_vec !== m_vec()) begin
        n_errors++;
        $display("FAIL lock_step%0d: got %h required %h", i, dut_vec, m_vec());
      end
    end
    n_checks++;
    if (locked !== 1'b1 || state !== 2'd2 || expected !== 8'd8 || err_count !== 8'd0) begin
      n_errors++;
      $display("FAIL lock_final: got lk=%b st=%0d exp=%0d cnt=%0d required 1 2 8 0",
               locked, state, expected, err_count);
    end
  endtask

  task automatic test_wrap();
    int seq[7] = '{251, 252, 253, 254, 255, 0, 1};
    cyc(1, 0, 0, 0);
    foreach (seq[i]) begin
      cyc(0, 1, seq[i], 0);
      n_checks++;
      if (dut_vec !== m_vec()) begin
        n_errors++;
        $display("FAIL wrap_step%0d: got %h required %h", i, dut_vec, m_vec());
      end
      if (i >= 2) begin
        n_checks++;
        if (locked !== 1'b1 || err_pulse !== 1'b0) begin
          n_errors++;
          $display("FAIL wrap_locked%0d: got lk=%b pl=%b required 1 0", i, locked, err_pulse);
        end
      end
    end
    n_checks++;
    if (expected !== 8'd2) begin
      n_errors++;
      $display("FAIL wrap_expected: got %0d required 2", expected);
    end
  endtask

  task automatic test_mismatch();
    int seq[3] = '{7, 8, 9};
    cyc(1, 0, 0, 0);
    foreach (seq[i]) cyc(0, 1, seq[i], 0);
    cyc(0, 1, 40, 0);
    n_checks++;
    if (err_pulse !== 1'b1 || err_count !== 8'd1 || state !== 2'd1 || expected !== 8'd41) begin
      n_errors++;
      $display("FAIL mismatch_hit: got pl=%b cnt=%0d st=%0d exp=%0d required 1 1 1 41",
               err_pulse, err_count, state, expected);
    end
    cyc(0, 0, 0, 0);
    n_checks++;
    if (err_pulse !== 1'b0 || dut_vec !== m_vec()) begin
      n_errors++;
      $display("FAIL mismatch_one_cycle: got %h required %h", dut_vec, m_vec());
    end
    cyc(0, 1, 41, 0);
    cyc(0, 1, 42, 0);
    n_checks++;
    if (locked !== 1'b1 || state !== 2'd2 || err_count !== 8'd1) begin
      n_errors++;
      $display("FAIL mismatch_relock: got lk=%b st=%0d cnt=%0d required 1 2 1",
               locked, state, err_count);
    end
  endtask

  task automatic test_back_to_back();
    cyc(1, 0, 0, 0);
    cyc(0, 1, 20, 0);
    cyc(0, 1, 21, 0);
    cyc(0, 1, 22, 0);
    cyc(0, 1, 90, 0);
    cyc(0, 1, 50, 0);
    n_checks++;
    if (err_pulse !== 1'b0 || err_count !== 8'd1 || state !== 2'd1 || expected !== 8'd51) begin
      n_errors++;
      $display("FAIL b2b_second: got pl=%b cnt=%0d st=%0d exp=%0d required 0 1 1 51",
               err_pulse, err_count, state, expected);
    end
  endtask

  task automatic test_saturation();
    int want;
    cyc(1, 0, 0, 0);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 258; i++) begin
      for (int k = 0; k < LN; k++) cyc(0, 1, m_exp, 0);
      cyc(0, 1, m_exp + 100, 0);
      want = (i + 1 > 255) ? 255 : i + 1;
      n_checks++;
      if (err_pulse !== 1'b1 || err_count !== 8'(want)) begin
        n_errors++;
        $display("FAIL sat_err%0d: got pl=%b cnt=%0d required 1 %0d", i, err_pulse, err_count, want);
      end
    end
  endtask

  task automatic test_reset_mid();
    cyc(1, 0, 0, 0);
    cyc(0, 1, 5, 0);
    cyc(0, 1, 6, 0);
    cyc(0, 1, 7, 0);
    cyc(1, 1, 8, 0);
    n_checks++;
    if (dut_vec !== 20'h0) begin
      n_errors++;
      $display("FAIL reset_locked: got %h required %h", dut_vec, 20'h0);
    end
    cyc(0, 1, 100, 0);
    cyc(1, 0, 0, 0);
    n_checks++;
    if (dut_vec !== 20'h0) begin
      n_errors++;
      $display("FAIL reset_sync: got %h required %h", dut_vec, 20'h0);
    end
  endtask

  task automatic test_dir();
    int seq[3] = '{1, 0, 255};
    cyc(1, 0, 0, 0);
    foreach (seq[i]) begin
      cyc(0, 1, seq[i], 1);
      n_checks++;
      if (dut_vec !== m_vec()) begin
        n_errors++;
        $display("FAIL dir_step%0d: got %h required %h", i, dut_vec, m_vec());
      end
    end
`ifdef COUNT_CHECKER_DIR_EN
    n_checks++;
    if (locked !== 1'b1 || expected !== 8'd254) begin
      n_errors++;
      $display("FAIL dir_down: got lk=%b exp=%0d required 1 254", locked, expected);
    end
`else
    n_checks++;
    if (locked !== 1'b0 || state !== 2'd1 || expected !== 8'd0) begin
      n_errors++;
      $display("FAIL dir_ignored: got lk=%b st=%0d exp=%0d required 0 1 0", locked, state, expected);
    end
`endif
  endtask

  task automatic test_random();
    bit r, v, d;
    int s;
    cyc(1, 0, 0, 0);
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 59) == 0);
      v = ($urandom_range(0, 3) != 0);
      d = 1'($urandom_range(0, 1));
      s = ($urandom_range(0, 9) < 7) ? m_exp : int'($urandom_range(0, 255));
      cyc(r, v, s, d);
      n_checks++;
      if (dut_vec !== m_vec()) begin
        n_errors++;
        $display("FAIL random%0d: got %h required %h", i, dut_vec, m_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_wrap();
    test_mismatch();
    test_back_to_back();
    test_saturation();
    test_reset_mid();
    test_dir();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
